// File: rtl/vlctx_symbol_scheduler.sv
// rtl/vlctx_symbol_scheduler.sv - VLC TX frame sequencer: preamble then data symbols onto one AXIS port.
// Each symbol waits for the IFFT done_tick, then a programmable guard gap.
module vlctx_symbol_scheduler #(
  parameter int DATA_W   = 32,
  parameter int PRE_SYMS = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [7:0]        num_syms,
  input  logic [7:0]        guard_interval,
  output logic              busy,
  output logic              frame_done_tick,
  output logic              err_tick,
  output logic [7:0]        sym_cnt,
  input  logic              done_tick,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic              s0_axis_tvalid,
  input  logic              s0_axis_tlast,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tvalid,
  input  logic              s1_axis_tlast,
  output logic              s1_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int PW = $clog2(PRE_SYMS + 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_GAP, S_DATA} state_t;

  state_t        state_q, state_d;
  logic [7:0]    n_q, n_d;
  logic [7:0]    g_q, g_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]    sym_cnt_q, sym_cnt_d;
  logic [TW-1:0] tout_q, tout_d;
  logic [7:0]    gap_q, gap_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          err_q, err_d;
  logic          go_next;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      g_q          <= '0;
      pre_cnt_q    <= '0;
      sym_cnt_q    <= '0;
      tout_q       <= '0;
      gap_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      g_q          <= g_d;
      pre_cnt_q    <= pre_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      tout_q       <= tout_d;
      gap_q        <= gap_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    g_d          = g_q;
    pre_cnt_d    = pre_cnt_q;
    sym_cnt_d    = sym_cnt_q;
    tout_d       = tout_q;
    gap_d        = gap_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    go_next      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d       = num_syms;
          g_d       = guard_interval;
          sym_cnt_d = '0;
          pre_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = S_PRE;
        end
      end
      S_PRE: begin
        if (s0_axis_tvalid && m_axis_tready && s0_axis_tlast) begin
          pre_cnt_d = pre_cnt_q + 1'b1;
          tout_d    = '0;
          state_d   = S_WAIT;
        end
      end
      S_DATA: begin
        if (s1_axis_tvalid && m_axis_tready && s1_axis_tlast) begin
          if (sym_cnt_q != 8'hFF) sym_cnt_d = sym_cnt_q + 8'd1;
          tout_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // done_tick takes priority over a timeout expiring on the same cycle
        if (done_tick) begin
          if (g_q != 8'd0) begin
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            go_next = 1'b1;
          end
        end else if (tout_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tout_d = tout_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == g_q - 8'd1) go_next = 1'b1;
        else                     gap_d   = gap_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (go_next) begin
      if (pre_cnt_q < PW'(PRE_SYMS)) begin
        state_d = S_PRE;
      end else if (sym_cnt_q < n_q) begin
        state_d = S_DATA;
      end else begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
    end
  end

  // Pure combinational mux: the selected source sees the mapper's backpressure directly.
  always_comb begin
    m_axis_tdata   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state_q)
      S_PRE: begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tlast   = s0_axis_tlast;
        s0_axis_tready = m_axis_tready;
      end
      S_DATA: begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast;
        s1_axis_tready = m_axis_tready;
      end
      default: ;
    endcase
  end

  assign busy            = busy_q;
  assign frame_done_tick = frame_done_q;
  assign err_tick        = err_q;
  assign sym_cnt         = sym_cnt_q;

endmodule

// File: tb/tb_vlctx_symbol_scheduler.sv
// tb/tb_vlctx_symbol_scheduler.sv - directed self-checking bench for vlctx_symbol_scheduler.
// Background process models both sources, the mapper sink and the IFFT done_tick.
module tb_vlctx_symbol_scheduler;

  localparam int DATA_W   = 32;
  localparam int PRE_SYMS = 2;
  localparam int TIMEOUT  = 64;
  localparam int LEN      = 16;
  localparam int DT_DLY   = 10;

  logic              aclk, aresetn, start, done_tick;
  logic [7:0]        num_syms, guard_interval, sym_cnt;
  logic              busy, frame_done_tick, err_tick;
  logic [DATA_W-1:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic              s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
  logic              s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
  logic              m_axis_tvalid, m_axis_tlast, m_axis_tready;

  vlctx_symbol_scheduler #(.DATA_W(DATA_W), .PRE_SYMS(PRE_SYMS), .TIMEOUT(TIMEOUT)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .num_syms(num_syms),
    .guard_interval(guard_interval), .busy(busy), .frame_done_tick(frame_done_tick),
    .err_tick(err_tick), .sym_cnt(sym_cnt), .done_tick(done_tick),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_pass = 0, n_chk = 0;
  int cyc = 0, pkt_idx = 0, w0 = 0, w1 = 0, dt_cnt = 0;
  int exp_seq [2] = '{0, 0};
  int fd_count = 0, err_count = 0, fd_cyc = 0, err_cyc = 0;
  int last_dt_cyc = 0, last_tl_cyc = 0, gap_min = 999, gap_max = 0;
  int n_pkt0 = 0, n_pkt1 = 0;
  bit dt_en = 1'b1, bp = 1'b0, gap_armed = 1'b0, s1_rdy_seen = 1'b0;
  bit busy_at_end = 1'b0, h0, h1, hm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin : model
    int src;
    bit exp_last;
    forever begin
      @(negedge aclk);
      cyc++;
      if (frame_done_tick) begin fd_count++; fd_cyc = cyc; busy_at_end = busy; end
      if (err_tick) begin err_count++; err_cyc = cyc; busy_at_end = busy; end
      if (s1_axis_tready) s1_rdy_seen = 1'b1;
      if (done_tick) begin
        last_dt_cyc = cyc;
        gap_armed   = 1'b1;
      end else if (gap_armed && m_axis_tvalid) begin
        if (cyc - last_dt_cyc < gap_min) gap_min = cyc - last_dt_cyc;
        if (cyc - last_dt_cyc > gap_max) gap_max = cyc - last_dt_cyc;
        gap_armed = 1'b0;
      end
      h0 = s0_axis_tvalid && s0_axis_tready;
      h1 = s1_axis_tvalid && s1_axis_tready;
      hm = m_axis_tvalid && m_axis_tready;
      if (hm) begin
        src      = (pkt_idx < PRE_SYMS) ? 0 : 1;
        exp_last = (exp_seq[src] % LEN) == LEN - 1;
        check("m_tdata", m_axis_tdata, {8'(src), 24'(exp_seq[src])});
        check("m_tlast", {31'd0, m_axis_tlast}, {31'd0, exp_last});
        exp_seq[src]++;
        if (exp_last) begin
          pkt_idx++;
          if (src == 0) n_pkt0++; else n_pkt1++;
          last_tl_cyc = cyc;
          if (dt_en) dt_cnt = DT_DLY;
        end
      end
      @(posedge aclk);
      #1;
      if (h0) w0++;
      if (h1) w1++;
      if (!bp) s0_axis_tvalid = 1'b1;
      else if (h0 || !s0_axis_tvalid) s0_axis_tvalid = 1'($urandom_range(0, 1));
      if (!bp) s1_axis_tvalid = 1'b1;
      else if (h1 || !s1_axis_tvalid) s1_axis_tvalid = 1'($urandom_range(0, 1));
      s0_axis_tdata = {8'd0, 24'(w0)};
      s0_axis_tlast = (w0 % LEN) == LEN - 1;
      s1_axis_tdata = {8'd1, 24'(w1)};
      s1_axis_tlast = (w1 % LEN) == LEN - 1;
      m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      done_tick = 1'b0;
      if (dt_cnt > 0) begin
        dt_cnt--;
        if (dt_cnt == 0) done_tick = 1'b1;
      end
    end
  end

  task automatic start_frame(input logic [7:0] n, input logic [7:0] g);
    @(posedge aclk);
    #1;
    num_syms = n; guard_interval = g; start = 1'b1;
    pkt_idx = 0; gap_armed = 1'b0; gap_min = 999; gap_max = 0; s1_rdy_seen = 1'b0;
    fd_count = 0; err_count = 0; n_pkt0 = 0; n_pkt1 = 0;
    @(posedge aclk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    bit ended = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge aclk);
      if (fd_count + err_count != 0) begin ended = 1'b1; break; end
    end
    check(tag, {31'd0, ended}, 32'd1);
    repeat (3) @(posedge aclk);
  endtask

  initial begin : stim
    bit seen;
    aresetn = 1'b0; start = 1'b0; done_tick = 1'b0; num_syms = '0; guard_interval = '0;
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0; s1_axis_tlast = 1'b0;
    s0_axis_tdata = '0; s1_axis_tdata = '0; m_axis_tready = 1'b1;
    repeat (3) @(negedge aclk);
    check("rst_outs", {25'd0, busy, frame_done_tick, err_tick, m_axis_tvalid,
                       s0_axis_tready, s1_axis_tready, 1'b0}, 32'd0);
    check("rst_sym_cnt", {24'd0, sym_cnt}, 32'd0);
    @(posedge aclk); #1; aresetn = 1'b1;
    repeat (2) @(posedge aclk);

    // T1: 2 preambles + 3 data symbols, guard 4
    start_frame(8'd3, 8'd4);
    @(negedge aclk);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_end("t1_end");
    check("t1_fd", fd_count, 1);
    check("t1_err", err_count, 0);
    check("t1_pkt0", n_pkt0, 2);
    check("t1_pkt1", n_pkt1, 3);
    check("t1_sym_cnt", {24'd0, sym_cnt}, 32'd3);
    check("t1_gap_min", gap_min, 5);
    check("t1_gap_max", gap_max, 5);
    check("t1_fd_lat", fd_cyc - last_dt_cyc, 5);
    check("t1_busy_end", {31'd0, busy_at_end}, 32'd0);

    // T2: preamble-only frame
    start_frame(8'd0, 8'd4);
    wait_end("t2_end");
    check("t2_fd", fd_count, 1);
    check("t2_pkt0", n_pkt0, 2);
    check("t2_pkt1", n_pkt1, 0);
    check("t2_s1_rdy", {31'd0, s1_rdy_seen}, 32'd0);
    check("t2_fd_lat", fd_cyc - last_dt_cyc, 5);
    check("t2_sym_cnt", {24'd0, sym_cnt}, 32'd0);

    // T3: zero guard
    start_frame(8'd1, 8'd0);
    wait_end("t3_end");
    check("t3_gap_min", gap_min, 1);
    check("t3_gap_max", gap_max, 1);
    check("t3_fd_lat", fd_cyc - last_dt_cyc, 1);
    check("t3_sym_cnt", {24'd0, sym_cnt}, 32'd1);

    // T4: done_tick withheld -> timeout abort
    dt_en = 1'b0;
    start_frame(8'd3, 8'd2);
    wait_end("t4_end");
    check("t4_err", err_count, 1);
    check("t4_fd", fd_count, 0);
    check("t4_err_lat", err_cyc - last_tl_cyc, TIMEOUT + 1);
    check("t4_busy_end", {31'd0, busy_at_end}, 32'd0);
    check("t4_sym_cnt", {24'd0, sym_cnt}, 32'd0);
    check("t4_pkt0", n_pkt0, 1);
    dt_en = 1'b1;

    // T5: random backpressure on both sides
    bp = 1'b1;
    start_frame(8'd4, 8'd2);
    wait_end("t5_end");
    bp = 1'b0;
    check("t5_fd", fd_count, 1);
    check("t5_pkt0", n_pkt0, 2);
    check("t5_pkt1", n_pkt1, 4);
    check("t5_sym_cnt", {24'd0, sym_cnt}, 32'd4);

    // T6a: start while busy is ignored
    start_frame(8'd2, 8'd1);
    repeat (5) @(posedge aclk);
    #1; num_syms = 8'd9; guard_interval = 8'd0; start = 1'b1;
    @(posedge aclk); #1; start = 1'b0;
    wait_end("t6_end");
    check("t6_fd", fd_count, 1);
    check("t6_pkt1", n_pkt1, 2);
    check("t6_sym_cnt", {24'd0, sym_cnt}, 32'd2);

    // T6b: async reset during a data symbol
    start_frame(8'd3, 8'd1);
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge aclk);
      if (s1_axis_tready) begin seen = 1'b1; break; end
    end
    check("t6_data_reached", {31'd0, seen}, 32'd1);
    #2; aresetn = 1'b0;
    #1;
    check("t6_async_outs", {25'd0, busy, frame_done_tick, err_tick, m_axis_tvalid,
                            s0_axis_tready, s1_axis_tready, 1'b0}, 32'd0);
    check("t6_async_sym", {24'd0, sym_cnt}, 32'd0);
    repeat (3) @(posedge aclk);
    #1; aresetn = 1'b1;
    repeat (2) @(posedge aclk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
